// File: rtl/cmp_pkg.sv
// Shared definitions for the round-robin compare arbiter: opcodes and FSM states.
package cmp_pkg;

    localparam logic [1:0] OP_GTU = 2'b00;
    localparam logic [1:0] OP_GTS = 2'b01;
    localparam logic [1:0] OP_EQ  = 2'b10;
    localparam logic [1:0] OP_LTS = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        RESPOND = 2'd2
    } state_t;

endpackage

// File: rtl/cmp_arbiter_if.sv
// Request/response bundle between requesters and the shared compare arbiter.
interface cmp_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ*2-1:0]     req_op;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [ID_W-1:0]          resp_id;
    logic                     resp_result;
    logic                     resp_n;
    logic                     resp_z;

    modport master (
        output req_valid, req_a, req_b, req_op, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_result, resp_n, resp_z
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, resp_ready,
        output req_ready, resp_valid, resp_id, resp_result, resp_n, resp_z
    );

endinterface

// File: rtl/cmp_core.sv
// Combinational relational compare: unsigned/signed greater-than, equality, signed less-than.
module cmp_core
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [1:0]       i_op,
    output logic             o_result,
    output logic             o_n,
    output logic             o_z
);
    logic w_ugt;
    logic w_eq;
    logic w_sdiff;
    logic w_sgt;
    logic w_slt;

    assign w_ugt   = (i_a > i_b);
    assign w_eq    = (i_a == i_b);
    assign w_sdiff = i_a[WIDTH-1] ^ i_b[WIDTH-1];

    // Differing signs decide alone; matching signs reduce to an unsigned compare.
    assign w_sgt = w_sdiff ? i_b[WIDTH-1] : w_ugt;
    assign w_slt = w_sdiff ? i_a[WIDTH-1] : (~w_ugt & ~w_eq);

    always_comb begin
        o_result = 1'b0;
        o_n      = 1'b0;
        case (i_op)
            OP_GTU: o_result = w_ugt;
            OP_GTS: begin
                o_result = w_sgt;
                o_n      = w_slt;
            end
            OP_EQ:  o_result = w_eq;
            OP_LTS: begin
                o_result = w_slt;
                o_n      = w_slt;
            end
            default: o_result = 1'b0;
        endcase
    end

    assign o_z = ~o_result;

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one compare core among NUM_REQ requesters,
// with a latched request and a registered, tagged response.
module cmp_arbiter
    import cmp_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32
) (
    input  logic          clk,
    input  logic          rst,
    cmp_arbiter_if.slave  bus
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    r_id;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [1:0]         r_op;
    logic               r_resp_valid;
    logic [ID_W-1:0]    r_resp_id;
    logic               r_result;
    logic               r_n;
    logic               r_z;

    logic [NUM_REQ-1:0] w_win;
    logic [NUM_REQ-1:0] w_ready;
    logic [ID_W-1:0]    w_gnt_id;
    logic               w_gnt_vld;
    logic               w_accept;
    logic               w_resp_hs;
    logic               w_result;
    logic               w_n;
    logic               w_z;

    // Valid bits rotated so bit k is requester (rr_ptr + k) mod NUM_REQ.
    assign w_win = NUM_REQ'({bus.req_valid, bus.req_valid} >> r_rr_ptr);

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_win[k]) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = ID_W'(int'(r_rr_ptr) + k -
                                  ((int'(r_rr_ptr) + k >= NUM_REQ) ? NUM_REQ : 0));
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (r_state == IDLE && w_gnt_vld)
            w_ready[w_gnt_id] = 1'b1;
    end

    assign w_accept  = |w_ready;
    assign w_resp_hs = r_resp_valid & bus.resp_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_gnt_vld) w_state_nxt = COMPARE;
            COMPARE: w_state_nxt = RESPOND;
            RESPOND: if (bus.resp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    cmp_core #(.WIDTH(WIDTH)) u_core (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_op     (r_op),
        .o_result (w_result),
        .o_n      (w_n),
        .o_z      (w_z)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_rr_ptr     <= '0;
            r_id         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_result     <= 1'b0;
            r_n          <= 1'b0;
            r_z          <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_a  <= bus.req_a[w_gnt_id*WIDTH +: WIDTH];
                r_b  <= bus.req_b[w_gnt_id*WIDTH +: WIDTH];
                r_op <= bus.req_op[w_gnt_id*2 +: 2];
                r_id <= w_gnt_id;
            end
            if (r_state == COMPARE) begin
                r_resp_valid <= 1'b1;
                r_resp_id    <= r_id;
                r_result     <= w_result;
                r_n          <= w_n;
                r_z          <= w_z;
            end else if (w_resp_hs) begin
                r_resp_valid <= 1'b0;
            end
            if (w_resp_hs)
                r_rr_ptr <= (r_resp_id == ID_W'(NUM_REQ - 1)) ? '0 : r_resp_id + 1'b1;
        end
    end

    assign bus.req_ready   = w_ready;
    assign bus.resp_valid  = r_resp_valid;
    assign bus.resp_id     = r_resp_id;
    assign bus.resp_result = r_result;
    assign bus.resp_n      = r_n;
    assign bus.resp_z      = r_z;

endmodule

// File: doc/cmp_arbiter.md
# cmp_arbiter

Round-robin controller that shares one 32-bit relational compare unit between several requesters in the ALU/CU datapath. Each requester presents an operand pair and a compare opcode over a valid/ready handshake. The block grants one requester at a time, latches its operands, and evaluates them in the shared compare core. It returns the result and flags (result, n, z), tagged with the requester id, over a second valid/ready handshake.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- WIDTH, 32: operand width.
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_a  input  NUM_REQ*WIDTH  operand a, requester i at bits [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  operand b, same packing.
- req_op  input  NUM_REQ*2  opcode per requester: 00 GT unsigned, 01 GT signed, 10 EQ, 11 LT signed.
- resp_valid  output  1  response valid.
- resp_ready  input  1  response consumer ready.
- resp_id  output  $clog2(NUM_REQ)  index of the served requester.
- resp_result  output  1  compare outcome.
- resp_n  output  1  signed ops: 1 when a < b (signed); unsigned and EQ ops: 0.
- resp_z  output  1  always the inverse of resp_result.

## Operation
- FSM states: IDLE, COMPARE, RESPOND.
- IDLE:
  - If no req_valid bit is set, stay in IDLE with req_ready all 0.
  - Otherwise grant the first valid requester, searching from rr_ptr upward with wrap NUM_REQ-1 -> 0.
  - Assert that requester's req_ready for this cycle only.
  - Latch a, b, op and id; go to COMPARE.
- COMPARE: the cmp_core output on the latched operands is registered into the result, n and z registers; go to RESPOND.
- RESPOND:
  - Hold resp_valid and all response fields stable until resp_ready is high.
  - On the handshake: rr_ptr <= (grant id + 1) mod NUM_REQ; go to IDLE.
- Arithmetic: unsigned and EQ compares are full WIDTH. Signed compares treat bit WIDTH-1 as the sign. No overflow is possible, because compares use magnitude and sign logic rather than a truncated difference.
- No request is accepted outside IDLE. While resp_ready is low, requesters stall.
- Requesters hold req_valid and their operands until req_ready. A request withdrawn before acceptance is simply not served.

## Timing
- Reset values: state IDLE, rr_ptr 0, req_ready 0, resp_valid 0, resp_id 0, resp_result 0, resp_n 0, resp_z 1.
- Reset asserted mid-operation aborts any latched request; no response is emitted for it.
- Latency: a request accepted in cycle T produces resp_valid in cycle T+2.
- Throughput: one compare per 3 cycles when resp_ready is held high.
- Simultaneous requests are served in round-robin order from rr_ptr. With all NUM_REQ valid and resp_ready high, grants cycle 0,1,2,3,0,... with no requester starved.
- req_ready is combinational from state, rr_ptr and req_valid. All response outputs are registered.

## Structure
- Package cmp_pkg holds:
  - opcode constants OP_GTU=2'b00, OP_GTS=2'b01, OP_EQ=2'b10, OP_LTS=2'b11;
  - FSM state encoding IDLE/COMPARE/RESPOND.
- Sub-module cmp_core: purely combinational.
  - Inputs: WIDTH-bit a and b, 2-bit op.
  - Outputs: result, n, z, per the rules above.
- cmp_arbiter contains the FSM, the round-robin pointer, the operand latches and the response registers.

## Test plan
- Reset: hold rst for 3 cycles, then release -> all outputs at their reset values, state IDLE, resp_z=1.
- Single request, requester 2, a=2, b=1, op GTU:
  - req_ready[2] pulses for one cycle at T;
  - resp_valid at T+2 with resp_id=2, result=1, n=0, z=0.
- Signed compare, a=32'hFFFF_FFFF (-1), b=1:
  - op GTS -> result=0, n=1, z=1;
  - op GTU -> result=1, n=0, z=0;
  - op EQ with a=b=1 -> result=1, n=0, z=0.
- All 4 requesters valid continuously with resp_ready=1 -> grant order 0,1,2,3,0; each response arrives 3 cycles after the previous one.
- Backpressure: hold resp_ready=0 for 5 cycles while in RESPOND -> response fields stay stable, req_ready stays 0. On release, the handshake completes and the next requester in round-robin order is granted.
- Assert rst in COMPARE while serving requester 1 -> outputs return to reset values; no resp_valid is produced for requester 1; rr_ptr is 0 after reset.
